trace_capture_buffer: RTL and testbench

Parametrised, synthesizable execution-trace recorder for the multi-cycle RISC-V core. It samples {PC, IR, state} into a circular buffer while armed and freezes on a PC-match or forced trigger after a programmable number of post-trigger samples. The captured window is then streamed out oldest-first over a valid/ready port. It sits beside the core and observes `PC`, `IR` and `state`, so debug visibility no longer depends on bench-only hierarchical peeking.

---
 rtl/trace_capture_buffer_if.sv | 25 ++
 rtl/trace_capture_buffer.sv | 205 ++++++++++++++++++++
 tb/tb_trace_capture_buffer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_capture_buffer_if.sv
// Readout stream of the trace capture buffer: a valid/ready handshake that
// carries one packed {pc, ir, st} entry per transfer, with a last-entry flag.
interface trace_capture_buffer_if #(
   parameter int DW = 68
);
   logic          rd_valid;
   logic          rd_ready;
   logic [DW-1:0] rd_data;
   logic          rd_last;

   // The buffer drives the stream; the consumer returns ready.
   modport master (
      output rd_valid,
      output rd_data,
      output rd_last,
      input  rd_ready
   );

   modport slave (
      input  rd_valid,
      input  rd_data,
      input  rd_last,
      output rd_ready
   );
endinterface

// File: rtl/trace_capture_buffer.sv
// Execution-trace recorder for the multi-cycle RISC-V core.
// While armed it records {pc, ir, st} samples into a circular buffer. A PC
// match or a forced trigger starts a programmable post-trigger window, after
// which the buffer freezes. The frozen window is streamed out oldest-first
// over the valid/ready read port and can be replayed as often as needed.
module trace_capture_buffer #(
   parameter int  PC_W  = 32,
   parameter int  IR_W  = 32,
   parameter int  ST_W  = 4,
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int DW    = PC_W + IR_W + ST_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   arm,
   input  logic                   sample_valid,
   input  logic [PC_W-1:0]        pc,
   input  logic [IR_W-1:0]        ir,
   input  logic [ST_W-1:0]        st,
   input  logic                   trig_en,
   input  logic [PC_W-1:0]        trig_pc,
   input  logic                   force_trig,
   input  logic [AW-1:0]          post_count,
   input  logic                   rd_start,
   trace_capture_buffer_if.master rd,
   output logic                   busy,
   output logic                   triggered,
   output logic                   done,
   output logic [AW:0]            count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_POST,
      S_DONE,
      S_READ
   } state_t;

   localparam logic [AW:0]   C_FULL    = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   C_CNT_ONE = (AW + 1)'(1);
   localparam logic [AW-1:0] C_REM_ONE = AW'(1);

   // Trace storage
   logic [DW-1:0] r_mem [DEPTH];

   // Control state
   state_t        r_state;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_count;
   logic [AW-1:0] r_remaining;
   logic          r_triggered;
   logic          r_busy;
   logic          r_done;

   // Readout state
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_rd_left;
   logic          r_rd_valid;
   logic          r_rd_last;
   logic [DW-1:0] r_rd_data;

   // Combinational helpers
   logic [DW-1:0] w_sample;
   logic          w_capture;
   logic          w_wr_en;
   logic          w_trig_hit;
   logic [AW-1:0] w_oldest;

   assign w_sample   = {pc, ir, st};
   assign w_capture  = (r_state == S_ARMED) || (r_state == S_POST);
   // arm wins over a coincident sample, so the fresh capture starts empty.
   assign w_wr_en    = sample_valid && w_capture && !arm;
   assign w_trig_hit = sample_valid && (force_trig || (trig_en && (pc == trig_pc)));
   // Once the buffer has wrapped, the slot about to be overwritten is the oldest.
   assign w_oldest   = (r_count == C_FULL) ? r_wr_ptr : '0;

   // Sample storage write port.
   // NOTE: the trace RAM has no reset; its contents are only ever read within
   // the first count entries, which are always written before being read.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= w_sample;
      end
   end

   // Write pointer and saturating fill count; both restart on every arm.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (arm) begin
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (w_wr_en) begin
         r_wr_ptr <= r_wr_ptr + 1'b1;
         if (r_count != C_FULL) begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   // Capture/readout FSM with registered status and read-port outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_triggered <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rd_ptr    <= '0;
         r_rd_left   <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_last   <= 1'b0;
         r_rd_data   <= '0;
      end else if (arm) begin
         // Re-arm from any state, aborting a readout in progress.
         r_state     <= S_ARMED;
         r_remaining <= post_count;
         r_triggered <= 1'b0;
         r_busy      <= 1'b1;
         r_done      <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_last   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Waiting for arm; samples and rd_start are ignored.
            end

            S_ARMED: begin
               if (w_trig_hit) begin
                  r_triggered <= 1'b1;
                  if (r_remaining == '0) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_POST;
                  end
               end
            end

            S_POST: begin
               if (sample_valid) begin
                  r_remaining <= r_remaining - 1'b1;
                  if (r_remaining == C_REM_ONE) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end

            S_DONE: begin
               // Present the oldest entry immediately; count is at least 1 here.
               if (rd_start) begin
                  r_state    <= S_READ;
                  r_done     <= 1'b0;
                  r_rd_valid <= 1'b1;
                  r_rd_data  <= r_mem[w_oldest];
                  r_rd_ptr   <= w_oldest + 1'b1;
                  r_rd_left  <= r_count - 1'b1;
                  r_rd_last  <= (r_count == C_CNT_ONE);
               end
            end

            S_READ: begin
               // Advance one entry per accepted transfer; hold while stalled.
               if (r_rd_valid && rd.rd_ready) begin
                  if (r_rd_last) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_rd_valid <= 1'b0;
                     r_rd_last  <= 1'b0;
                  end else begin
                     r_rd_data <= r_mem[r_rd_ptr];
                     r_rd_ptr  <= r_rd_ptr + 1'b1;
                     r_rd_left <= r_rd_left - 1'b1;
                     r_rd_last <= (r_rd_left == C_CNT_ONE);
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign rd.rd_valid = r_rd_valid;
   assign rd.rd_data  = r_rd_data;
   assign rd.rd_last  = r_rd_last;
   assign busy        = r_busy;
   assign triggered   = r_triggered;
   assign done        = r_done;
   assign count       = r_count;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed testbench for trace_capture_buffer (DEPTH = 16).
// Inputs change 1 time unit after the rising edge; outputs are read at the
// same point, i.e. they show the state produced by the preceding edge.
module tb_trace_capture_buffer;

   localparam int PC_W  = 32;
   localparam int IR_W  = 32;
   localparam int ST_W  = 4;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int DW    = PC_W + IR_W + ST_W;

   logic            clk          = 1'b0;
   logic            reset        = 1'b0;
   logic            arm          = 1'b0;
   logic            sample_valid = 1'b0;
   logic [PC_W-1:0] pc           = '0;
   logic [IR_W-1:0] ir           = '0;
   logic [ST_W-1:0] st           = '0;
   logic            trig_en      = 1'b0;
   logic [PC_W-1:0] trig_pc      = '0;
   logic            force_trig   = 1'b0;
   logic [AW-1:0]   post_count   = '0;
   logic            rd_start     = 1'b0;
   logic            busy;
   logic            triggered;
   logic            done;
   logic [AW:0]     count;

   int n_checks = 0;
   int n_errors = 0;

   trace_capture_buffer_if #(.DW(DW)) rd_if ();

   trace_capture_buffer #(
      .PC_W (PC_W),
      .IR_W (IR_W),
      .ST_W (ST_W),
      .DEPTH(DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .arm         (arm),
      .sample_valid(sample_valid),
      .pc          (pc),
      .ir          (ir),
      .st          (st),
      .trig_en     (trig_en),
      .trig_pc     (trig_pc),
      .force_trig  (force_trig),
      .post_count  (post_count),
      .rd_start    (rd_start),
      .rd          (rd_if),
      .busy        (busy),
      .triggered   (triggered),
      .done        (done),
      .count       (count)
   );

   always #5 clk = ~clk;

   // Reference encoding of the sample stream: ir and st derived from pc.
   function automatic logic [IR_W-1:0] ir_of(input logic [PC_W-1:0] p);
      return p ^ 32'hA5A5_0F0F;
   endfunction

   function automatic logic [ST_W-1:0] st_of(input logic [PC_W-1:0] p);
      return p[5:2];
   endfunction

   function automatic logic [DW-1:0] entry_of(input logic [PC_W-1:0] p);
      return {p, ir_of(p), st_of(p)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_sample(input logic [PC_W-1:0] p);
      sample_valid = 1'b1;
      pc           = p;
      ir           = ir_of(p);
      st           = st_of(p);
   endtask

   task automatic do_arm(input logic [AW-1:0] post, input logic en, input logic [PC_W-1:0] tpc);
      post_count = post;
      trig_en    = en;
      trig_pc    = tpc;
      arm        = 1'b1;
      step();
      arm        = 1'b0;
   endtask

   // Start a readout and check n entries with PCs pc0, pc0+4, ...
   // With bp set, odd entries are stalled two cycles (ready 1,0,0,1,1,0,0,1...).
   task automatic read_and_check(input string name, input int n, input logic [PC_W-1:0] pc0,
                                 input bit bp);
      logic [DW-1:0] exp_d;
      logic          exp_last;
      rd_if.rd_ready = 1'b0;
      rd_start       = 1'b1;
      step();
      rd_start       = 1'b0;
      for (int i = 0; i < n; i++) begin
         exp_d    = entry_of(pc0 + 32'(4 * i));
         exp_last = (i == n - 1);
         if (bp && (i % 2 == 1)) begin
            for (int s = 0; s < 2; s++) begin
               rd_if.rd_ready = 1'b0;
               step();
               n_checks++;
               if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== exp_d || rd_if.rd_last !== exp_last) begin
                  n_errors++;
                  $display("FAIL %s_stall%0d_%0d: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                           name, i, s, rd_if.rd_valid, rd_if.rd_data, rd_if.rd_last, exp_d, exp_last);
               end
            end
         end
         rd_if.rd_ready = 1'b1;
         n_checks++;
         if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== exp_d || rd_if.rd_last !== exp_last) begin
            n_errors++;
            $display("FAIL %s_entry%0d: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                     name, i, rd_if.rd_valid, rd_if.rd_data, rd_if.rd_last, exp_d, exp_last);
         end
         step();
      end
      rd_if.rd_ready = 1'b0;
      n_checks++;
      if (rd_if.rd_valid !== 1'b0 || done !== 1'b1) begin
         n_errors++;
         $display("FAIL %s_end: got valid=%b done=%b, expected valid=0 done=1", name, rd_if.rd_valid, done);
      end
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if (busy !== 1'b0 || triggered !== 1'b0 || done !== 1'b0 || count !== 5'd0) begin
         n_errors++;
         $display("FAIL reset_status: got busy=%b trig=%b done=%b count=%0d, expected all 0",
                  busy, triggered, done, count);
      end
      n_checks++;
      if (rd_if.rd_valid !== 1'b0 || rd_if.rd_last !== 1'b0 || rd_if.rd_data !== '0) begin
         n_errors++;
         $display("FAIL reset_rdport: got valid=%b last=%b data=%h, expected all 0",
                  rd_if.rd_valid, rd_if.rd_last, rd_if.rd_data);
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_idle_samples();
      for (int k = 0; k < 4; k++) begin
         drive_sample(32'(4 * k));
         step();
         sample_valid = 1'b0;
         step();
      end
      n_checks++;
      if (count !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL idle_samples: got count=%0d busy=%b done=%b, expected 0 0 0", count, busy, done);
      end
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      n_checks++;
      if (rd_if.rd_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL idle_rd_start: got rd_valid=%b, expected 0", rd_if.rd_valid);
      end
   endtask

   task automatic test_basic_capture();
      do_arm(4'd3, 1'b1, 32'h0000_000C);
      n_checks++;
      if (busy !== 1'b1 || count !== 5'd0 || triggered !== 1'b0 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL basic_armed: got busy=%b count=%0d trig=%b done=%b, expected 1 0 0 0",
                  busy, count, triggered, done);
      end
      for (int k = 0; k < 9; k++) begin
         drive_sample(32'(4 * k));
         step();
         if (k == 0) begin
            n_checks++;
            if (count !== 5'd1) begin
               n_errors++;
               $display("FAIL basic_first_count: got %0d, expected 1", count);
            end
         end
         if (k == 3) begin
            n_checks++;
            if (triggered !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
               n_errors++;
               $display("FAIL basic_trigger: got trig=%b busy=%b done=%b, expected 1 1 0", triggered, busy, done);
            end
         end
         if (k == 6) begin
            n_checks++;
            if (done !== 1'b1 || busy !== 1'b0 || count !== 5'd7) begin
               n_errors++;
               $display("FAIL basic_done: got done=%b busy=%b count=%0d, expected 1 0 7", done, busy, count);
            end
         end
      end
      sample_valid = 1'b0;
      n_checks++;
      if (count !== 5'd7 || done !== 1'b1) begin
         n_errors++;
         $display("FAIL basic_frozen: got count=%0d done=%b, expected 7 1", count, done);
      end
      read_and_check("basic", 7, 32'h0, 1'b0);
   endtask

   task automatic test_wrap();
      do_arm(4'd2, 1'b1, 32'h0000_006C);
      for (int k = 0; k < 30; k++) begin
         drive_sample(32'(4 * k));
         step();
         if (k == 26) begin
            n_checks++;
            if (triggered !== 1'b0 || count !== 5'd16) begin
               n_errors++;
               $display("FAIL wrap_pretrig: got trig=%b count=%0d, expected 0 16", triggered, count);
            end
         end
         if (k == 27) begin
            n_checks++;
            if (triggered !== 1'b1 || busy !== 1'b1) begin
               n_errors++;
               $display("FAIL wrap_trigger: got trig=%b busy=%b, expected 1 1", triggered, busy);
            end
         end
         if (k == 29) begin
            n_checks++;
            if (done !== 1'b1 || count !== 5'd16) begin
               n_errors++;
               $display("FAIL wrap_done: got done=%b count=%0d, expected 1 16", done, count);
            end
         end
      end
      sample_valid = 1'b0;
      read_and_check("wrap", 16, 32'h0000_0038, 1'b0);
   endtask

   task automatic test_force_post0();
      // PC match is disabled; 0x08 passes by without triggering.
      do_arm(4'd0, 1'b0, 32'h0000_0008);
      force_trig = 1'b1;
      step();
      force_trig = 1'b0;
      n_checks++;
      if (triggered !== 1'b0 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL force_unqualified: got trig=%b busy=%b, expected 0 1", triggered, busy);
      end
      for (int k = 0; k < 5; k++) begin
         drive_sample(32'(4 * k));
         force_trig = (k == 4);
         step();
         if (k == 3) begin
            n_checks++;
            if (triggered !== 1'b0 || busy !== 1'b1 || count !== 5'd4) begin
               n_errors++;
               $display("FAIL force_pretrig: got trig=%b busy=%b count=%0d, expected 0 1 4", triggered, busy, count);
            end
         end
      end
      sample_valid = 1'b0;
      force_trig   = 1'b0;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || triggered !== 1'b1 || count !== 5'd5) begin
         n_errors++;
         $display("FAIL force_done: got done=%b busy=%b trig=%b count=%0d, expected 1 0 1 5",
                  done, busy, triggered, count);
      end
      read_and_check("force", 5, 32'h0, 1'b0);
   endtask

   task automatic test_backpressure();
      read_and_check("bp_first", 5, 32'h0, 1'b1);
      read_and_check("bp_replay", 5, 32'h0, 1'b1);
   endtask

   task automatic test_arm_mid_read();
      rd_start = 1'b1;
      step();
      rd_start       = 1'b0;
      rd_if.rd_ready = 1'b1;
      step();
      rd_if.rd_ready = 1'b0;
      n_checks++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== entry_of(32'h4)) begin
         n_errors++;
         $display("FAIL midread_second: got valid=%b data=%h, expected 1 %h",
                  rd_if.rd_valid, rd_if.rd_data, entry_of(32'h4));
      end
      do_arm(4'd5, 1'b0, 32'h0);
      n_checks++;
      if (rd_if.rd_valid !== 1'b0 || count !== 5'd0 || busy !== 1'b1 || done !== 1'b0 || triggered !== 1'b0) begin
         n_errors++;
         $display("FAIL midread_arm: got valid=%b count=%0d busy=%b done=%b trig=%b, expected 0 0 1 0 0",
                  rd_if.rd_valid, count, busy, done, triggered);
      end
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
      n_checks++;
      if (rd_if.rd_valid !== 1'b0 || busy !== 1'b1) begin
         n_errors++;
         $display("FAIL armed_rd_start: got valid=%b busy=%b, expected 0 1", rd_if.rd_valid, busy);
      end
      drive_sample(32'h0000_0100);
      step();
      sample_valid = 1'b0;
      n_checks++;
      if (count !== 5'd1) begin
         n_errors++;
         $display("FAIL midread_restart: got count=%0d, expected 1", count);
      end
   endtask

   task automatic test_reset_mid_post();
      drive_sample(32'h0000_0104);
      force_trig = 1'b1;
      step();
      force_trig = 1'b0;
      drive_sample(32'h0000_0108);
      step();
      sample_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || triggered !== 1'b1 || done !== 1'b0 || count !== 5'd3) begin
         n_errors++;
         $display("FAIL post_state: got busy=%b trig=%b done=%b count=%0d, expected 1 1 0 3",
                  busy, triggered, done, count);
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || triggered !== 1'b0 || done !== 1'b0 || count !== 5'd0 ||
          rd_if.rd_valid !== 1'b0 || rd_if.rd_last !== 1'b0 || rd_if.rd_data !== '0) begin
         n_errors++;
         $display("FAIL async_reset: got busy=%b trig=%b done=%b count=%0d valid=%b last=%b data=%h, expected all 0",
                  busy, triggered, done, count, rd_if.rd_valid, rd_if.rd_last, rd_if.rd_data);
      end
      #2;
      reset = 1'b1;
      step();
      drive_sample(32'h0000_0200);
      step();
      sample_valid = 1'b0;
      step();
      n_checks++;
      if (count !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_idle: got count=%0d busy=%b done=%b, expected 0 0 0", count, busy, done);
      end
   endtask

   initial begin
      rd_if.rd_ready = 1'b0;
      test_reset();
      test_idle_samples();
      test_basic_capture();
      test_wrap();
      test_force_post0();
      test_backpressure();
      test_arm_mid_read();
      test_reset_mid_post();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global time bound so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
